cellrv32_gptmr_sched: RTL and testbench
=======================================

# cellrv32_gptmr_sched

Multi-channel timeout scheduler that time-shares the single General Purpose Timer among `NUM_CH` software-invisible requesters. It keeps one remaining-time value per channel. It acts as a bus master on the GPTMR register interface, programming the timer in single-shot mode with the nearest deadline. On each timer interrupt or new command it retires expired channels and reprograms the timer. It sits between the on-chip requesters (e.g. DMA/UART watchdogs) and the GPTMR slave port.

## Interface
- `NUM_CH`, 4: number of timeout channels, 1..8.
- `PRSC`, 3'b000: prescaler select written to GPTMR ctrl bits [3:1] on every start.
- `clk_i` in 1: global clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_cancel_i` in 1: 1 = cancel channel, 0 = arm channel.
- `cmd_ch_i` in `$clog2(NUM_CH)` (min 1): target channel.
- `cmd_dur_i` in 32: timeout in prescaled ticks (arm only).
- `expire_o` out `NUM_CH`: one-cycle pulse per expired channel.
- `armed_o` out `NUM_CH`: channel currently armed.
- `busy_o` out 1: state not IDLE/RUN.
- `err_o` out 1: bus timeout sticky flag (see Configuration).
- `tmr_addr_o` out 32: GPTMR register address (`gptmr_ctrl_addr_c` / `gptmr_thres_addr_c` / `gptmr_count_addr_c`).
- `tmr_rden_o`, `tmr_wren_o` out 1: single-cycle access strobes.
- `tmr_data_o` out 32: write data, held stable until ack.
- `tmr_data_i` in 32: read data, valid with ack.
- `tmr_ack_i` in 1: GPTMR transfer acknowledge.
- `tmr_irq_i` in 1: GPTMR match interrupt (level).

## Operation
- States: INIT, IDLE, RUN, STOP, READ, UPDATE, CLR, THRES, START.
- Bus access: strobe for 1 cycle, then wait for `tmr_ack_i`; the next access issues no earlier than the cycle after ack.
- INIT (reset state): write ctrl=0 → IDLE. This guarantees a stopped timer after a mid-operation reset.
- IDLE: `cmd_ready_o`=1. On accept, latch the command and go to UPDATE with elapsed=0.
- RUN: `cmd_ready_o`=1. On accept or `tmr_irq_i`=1, latch the event and go to STOP.
- STOP: write ctrl=0 (clears irq, freezes count). READ: read count → elapsed.
- UPDATE (1 cycle):
  - For each armed channel, rem = max(rem − elapsed, 0). Channels with rem==0 pulse `expire_o` and disarm.
  - Then apply the latched command. Arm overwrites rem and sets armed, even if already armed. Cancel clears armed; cancelling an unarmed channel is a no-op.
  - Arm with dur 0 sets rem=0; it expires in the next UPDATE pass, which is forced immediately via CLR→THRES(0)→START.
  - If none armed → IDLE. Else thres = min rem over armed channels.
- CLR: write count=0. THRES: write thres. START: write ctrl = {mode=0, PRSC, en=1} → RUN.
- Expire-then-command order: a channel that expires and is re-armed in the same UPDATE pulses `expire_o` and stays armed.
- Timer is frozen STOP→START. Ticks in that window are not counted; per-reschedule drift is ≤ the window length, which is accepted.

## Timing
- Reset values: `cmd_ready_o`=0, `expire_o`=0, `armed_o`=0, `busy_o`=1 (INIT), `err_o`=0, strobes 0, `tmr_addr_o`/`tmr_data_o`=0. All rem cleared.
- `cmd_ready_o` is combinational from state and forced 0 while `rst_i`=1.
- `expire_o` is registered: it asserts the cycle after UPDATE, for exactly 1 cycle.
- With a 1-cycle-ack slave: RUN→RUN reschedule takes 11 cycles (STOP 2, READ 2, UPDATE 1, CLR 2, THRES 2, START 2). IDLE→RUN takes 7 cycles.
- `tmr_irq_i` is sampled only in RUN. Commands and irq in the same RUN cycle are handled in one pass.

## Configuration
- `CELLRV32_GPTMR_SCHED_BUSTO_EN` defined:
  - A 4-bit counter aborts any bus wait after 16 cycles without `tmr_ack_i`.
  - On abort: set `err_o` (cleared only by reset), disarm all channels without expire pulses, go to IDLE.
- Not defined: waits for ack indefinitely; `err_o` tied 0.

## Test plan
- Reset with GPTMR model left enabled → ctrl address written with 0. `cmd_ready_o` rises the cycle after ack.
- Arm ch0 dur 100, PRSC 0 → writes count=0, thres=100, ctrl=0x01. `expire_o[0]` pulses about 100 cycles later, `armed_o[0]` clears, ctrl=0 written, IDLE.
- Arm ch0 100; when count=40, arm ch1 30 → thres 30 programmed (ch0 rem 60). ch1 expires first, then thres 30 is reprogrammed for ch0 and ch0 expires.
- Arm ch2 and ch3 dur 50 → both `expire_o` bits pulse in the same cycle. Arm dur 0 → expires with thres 0 programmed.
- Cancel armed ch1 → no pulse, `armed_o[1]`=0, thres recomputed. Cancel unarmed ch → no-op, timer reprogrammed unchanged.
- With the macro defined, hold `tmr_ack_i`=0 → `err_o`=1 after 16 cycles, `armed_o`=0, IDLE. Without the macro, FSM stays waiting.

Source files
------------

// File: rtl/cellrv32_gptmr_sched.sv
// cellrv32_gptmr_sched
// Multi-channel timeout scheduler sharing the single general purpose timer. Keeps one remaining
// time per channel, programs the timer in single-shot mode with the nearest deadline and retires
// expired channels on each timer interrupt or new command.
//
// Optional feature: define CELLRV32_GPTMR_SCHED_BUSTO_EN to abort bus waits after 16 cycles
// without ack (sets sticky err_o, disarms everything silently, returns to idle).
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   cmd_valid_i/ready_o    command handshake; cmd_cancel_i selects cancel (1) or arm (0)
//   cmd_ch_i, cmd_dur_i    target channel and timeout in prescaled ticks
//   expire_o               one-cycle pulse per expired channel
//   armed_o                channel currently armed
//   busy_o                 scheduler is not in IDLE/RUN
//   err_o                  sticky bus timeout flag
//   tmr_*                  bus master port towards the GPTMR register slave
module cellrv32_gptmr_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter logic [2:0]  PRSC   = 3'b000
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           cmd_valid_i,
  output logic                                           cmd_ready_o,
  input  logic                                           cmd_cancel_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch_i,
  input  logic [31:0]                                    cmd_dur_i,
  output logic [NUM_CH-1:0]                              expire_o,
  output logic [NUM_CH-1:0]                              armed_o,
  output logic                                           busy_o,
  output logic                                           err_o,
  output logic [31:0]                                    tmr_addr_o,
  output logic                                           tmr_rden_o,
  output logic                                           tmr_wren_o,
  output logic [31:0]                                    tmr_data_o,
  input  logic [31:0]                                    tmr_data_i,
  input  logic                                           tmr_ack_i,
  input  logic                                           tmr_irq_i
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [31:0] gptmr_ctrl_addr_c  = 32'hFFFF_FF60;
  localparam logic [31:0] gptmr_thres_addr_c = 32'hFFFF_FF64;
  localparam logic [31:0] gptmr_count_addr_c = 32'hFFFF_FF68;

  typedef enum logic [3:0] {
    StInit, StIdle, StRun, StStop, StRead, StUpdate, StClr, StThres, StStart
  } state_e;

  state_e             state_q, state_d;
  logic               issued_q, issued_d;   // strobe sent, waiting for ack
  logic [31:0]        rem_q [NUM_CH];
  logic [31:0]        rem_d [NUM_CH];
  logic [NUM_CH-1:0]  armed_q, armed_d;
  logic [NUM_CH-1:0]  expire_q, expire_d;
  logic [31:0]        elapsed_q, elapsed_d;
  logic [31:0]        thres_q, thres_d;
  logic               pend_q, pend_d;       // a command is latched for the next UPDATE
  logic               cancel_q, cancel_d;
  logic [ChW-1:0]     ch_q, ch_d;
  logic [31:0]        dur_q, dur_d;
  logic [31:0]        min_rem;

  logic               acc_rd, acc_wr, acc_done;
  logic [31:0]        acc_addr, acc_data;

`ifdef CELLRV32_GPTMR_SCHED_BUSTO_EN
  logic [3:0]         to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
`endif

  // Bus access decode; address/data depend only on state so they stay stable until ack.
  always_comb begin
    acc_rd   = 1'b0;
    acc_wr   = 1'b0;
    acc_addr = '0;
    acc_data = '0;
    unique case (state_q)
      StInit, StStop: begin
        acc_wr   = 1'b1;
        acc_addr = gptmr_ctrl_addr_c;
      end
      StRead: begin
        acc_rd   = 1'b1;
        acc_addr = gptmr_count_addr_c;
      end
      StClr: begin
        acc_wr   = 1'b1;
        acc_addr = gptmr_count_addr_c;
      end
      StThres: begin
        acc_wr   = 1'b1;
        acc_addr = gptmr_thres_addr_c;
        acc_data = thres_q;
      end
      StStart: begin
        acc_wr   = 1'b1;
        acc_addr = gptmr_ctrl_addr_c;
        acc_data = {27'd0, 1'b0, PRSC, 1'b1};  // single-shot mode, prescaler, enable
      end
      default: ;
    endcase
  end

  assign acc_done    = issued_q & tmr_ack_i;
  assign tmr_wren_o  = ~rst_i & acc_wr & ~issued_q;
  assign tmr_rden_o  = ~rst_i & acc_rd & ~issued_q;
  assign tmr_addr_o  = rst_i ? '0 : acc_addr;
  assign tmr_data_o  = rst_i ? '0 : acc_data;
  assign cmd_ready_o = ~rst_i & ((state_q == StIdle) | (state_q == StRun));
  assign busy_o      = ~((state_q == StIdle) | (state_q == StRun));
  assign expire_o    = expire_q;
  assign armed_o     = armed_q;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    rem_d     = rem_q;
    armed_d   = armed_q;
    expire_d  = '0;
    elapsed_d = elapsed_q;
    thres_d   = thres_q;
    pend_d    = pend_q;
    cancel_d  = cancel_q;
    ch_d      = ch_q;
    dur_d     = dur_q;
    min_rem   = '1;

    if ((acc_rd | acc_wr) & ~issued_q) issued_d = 1'b1;
    if (acc_done) issued_d = 1'b0;

    unique case (state_q)
      StInit:  if (acc_done) state_d = StIdle;
      StIdle: begin
        if (cmd_valid_i) begin
          pend_d    = 1'b1;
          cancel_d  = cmd_cancel_i;
          ch_d      = cmd_ch_i;
          dur_d     = cmd_dur_i;
          elapsed_d = '0;
          state_d   = StUpdate;
        end
      end
      StRun: begin
        if (cmd_valid_i | tmr_irq_i) begin
          pend_d   = cmd_valid_i;
          cancel_d = cmd_cancel_i;
          ch_d     = cmd_ch_i;
          dur_d    = cmd_dur_i;
          state_d  = StStop;
        end
      end
      StStop:  if (acc_done) state_d = StRead;
      StRead: begin
        if (acc_done) begin
          elapsed_d = tmr_data_i;
          state_d   = StUpdate;
        end
      end
      StUpdate: begin
        // Retire first, then apply the command, so expire-and-rearm pulses and stays armed.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (armed_q[i]) begin
            if (rem_q[i] <= elapsed_q) begin
              rem_d[i]    = '0;
              armed_d[i]  = 1'b0;
              expire_d[i] = 1'b1;
            end else begin
              rem_d[i] = rem_q[i] - elapsed_q;
            end
          end
          if (pend_q && (ch_q == ChW'(i))) begin
            if (cancel_q) begin
              armed_d[i] = 1'b0;
            end else begin
              armed_d[i] = 1'b1;
              rem_d[i]   = dur_q;
            end
          end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (armed_d[i] && (rem_d[i] < min_rem)) min_rem = rem_d[i];
        end
        pend_d  = 1'b0;
        thres_d = min_rem;
        state_d = (|armed_d) ? StClr : StIdle;
      end
      StClr:   if (acc_done) state_d = StThres;
      StThres: if (acc_done) state_d = StStart;
      StStart: if (acc_done) state_d = StRun;
      default: state_d = StInit;
    endcase

`ifdef CELLRV32_GPTMR_SCHED_BUSTO_EN
    err_d    = err_q;
    to_cnt_d = '0;
    if (issued_q && !tmr_ack_i) begin
      if (to_cnt_q == 4'hF) begin
        err_d    = 1'b1;
        armed_d  = '0;
        expire_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) rem_d[i] = '0;
        issued_d = 1'b0;
        pend_d   = 1'b0;
        state_d  = StIdle;
      end else begin
        to_cnt_d = to_cnt_q + 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StInit;
      issued_q  <= 1'b0;
      rem_q     <= '{default: '0};
      armed_q   <= '0;
      expire_q  <= '0;
      elapsed_q <= '0;
      thres_q   <= '0;
      pend_q    <= 1'b0;
      cancel_q  <= 1'b0;
      ch_q      <= '0;
      dur_q     <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      rem_q     <= rem_d;
      armed_q   <= armed_d;
      expire_q  <= expire_d;
      elapsed_q <= elapsed_d;
      thres_q   <= thres_d;
      pend_q    <= pend_d;
      cancel_q  <= cancel_d;
      ch_q      <= ch_d;
      dur_q     <= dur_d;
    end
  end

`ifdef CELLRV32_GPTMR_SCHED_BUSTO_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cellrv32_gptmr_sched.sv
module tb_cellrv32_gptmr_sched;

  localparam logic [31:0] CtrlA  = 32'hFFFF_FF60;
  localparam logic [31:0] ThresA = 32'hFFFF_FF64;
  localparam logic [31:0] CountA = 32'hFFFF_FF68;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_cancel_i = 1'b0;
  logic [1:0]  cmd_ch_i = '0;
  logic [31:0] cmd_dur_i = '0;
  logic        cmd_ready_o, busy_o, err_o, tmr_rden_o, tmr_wren_o;
  logic [3:0]  expire_o, armed_o;
  logic [31:0] tmr_addr_o, tmr_data_o;
  logic [31:0] tmr_data_i = '0;
  logic        tmr_ack_i = 1'b0;
  logic        tmr_irq_i;

  always #5 clk = ~clk;

  cellrv32_gptmr_sched #(.NUM_CH(4), .PRSC(3'b000)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_cancel_i(cmd_cancel_i), .cmd_ch_i(cmd_ch_i), .cmd_dur_i(cmd_dur_i),
    .expire_o(expire_o), .armed_o(armed_o), .busy_o(busy_o), .err_o(err_o),
    .tmr_addr_o(tmr_addr_o), .tmr_rden_o(tmr_rden_o), .tmr_wren_o(tmr_wren_o),
    .tmr_data_o(tmr_data_o), .tmr_data_i(tmr_data_i), .tmr_ack_i(tmr_ack_i),
    .tmr_irq_i(tmr_irq_i)
  );

  // GPTMR slave model: one tick per cycle, writes win over the tick, ack one cycle after strobe
  // unless stalled. Starts enabled to mimic a reset in the middle of operation.
  logic        tm_en = 1'b1;
  logic [31:0] tm_cnt = 32'd123, tm_thres = 32'd500;
  logic        stall = 1'b0, ack_pend = 1'b0;
  assign tmr_irq_i = tm_en && (tm_cnt >= tm_thres);

  always @(posedge clk) begin
    tmr_ack_i <= 1'b0;
    if (tmr_wren_o || tmr_rden_o) begin
      if (stall) ack_pend <= 1'b1;
      else       tmr_ack_i <= 1'b1;
      if (tmr_rden_o) tmr_data_i <= tm_cnt;
    end else if (ack_pend && !stall) begin
      ack_pend  <= 1'b0;
      tmr_ack_i <= 1'b1;
    end
    if (tmr_wren_o && tmr_addr_o == CtrlA)       tm_en <= tmr_data_o[0];
    else if (tmr_wren_o && tmr_addr_o == CountA) tm_cnt <= tmr_data_o;
    else if (tm_en)                              tm_cnt <= tm_cnt + 32'd1;
    if (tmr_wren_o && tmr_addr_o == ThresA) tm_thres <= tmr_data_o;
  end

  int n_cmp = 0, n_err = 0, n_exp_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Bus scoreboard: expected accesses pushed with the stimulus, popped on each strobe.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;
  bus_t exp_q[$];

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask
  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'd0});
  endtask

  always @(negedge clk) begin
    if (expire_o != 0) n_exp_pulses++;
    if (!rst_i && (tmr_wren_o || tmr_rden_o)) begin
      if (exp_q.size() == 0) begin
        timeout("bus_unexpected_access");
        $display("  access addr %h data %h", tmr_addr_o, tmr_data_o);
      end else begin
        bus_t e;
        e = exp_q.pop_front();
        chk("bus_dir_wr", {31'd0, tmr_wren_o}, {31'd0, e.wr});
        chk("bus_addr", tmr_addr_o, e.addr);
        if (e.wr) chk("bus_wdata", tmr_data_o, e.data);
      end
    end
  end

  task automatic send(input logic cancel, input logic [1:0] ch, input logic [31:0] dur,
                      output logic [31:0] cnt);
    int k = 0;
    cnt = '0;
    while (!cmd_ready_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready_o) begin
      timeout("cmd_ready_wait");
      return;
    end
    cmd_valid_i  = 1'b1;
    cmd_cancel_i = cancel;
    cmd_ch_i     = ch;
    cmd_dur_i    = dur;
    cnt          = tm_cnt;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_exp(input int lim, output logic [3:0] m, output int cyc);
    m = '0;
    cyc = 0;
    while (cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (expire_o != 0) begin
        m = expire_o;
        return;
      end
    end
    timeout("expire_wait");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o && armed_o == 0) return;
    end
    timeout("idle_wait");
  endtask

  task automatic wait_run();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready_o && armed_o != 0) return;
    end
    timeout("run_wait");
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] dur;
    logic [3:0]  mask;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [31:0] c, r0, r1, d3;
    logic [3:0]  m;
    int          cyc, pulses;

    vecs[0] = '{ch: 2'd0, dur: 32'd100, mask: 4'b0001};
    vecs[1] = '{ch: 2'd1, dur: 32'd7,   mask: 4'b0010};
    vecs[2] = '{ch: 2'd3, dur: 32'd1,   mask: 4'b1000};
    vecs[3] = '{ch: 2'd2, dur: 32'd0,   mask: 4'b0100};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 0);
    chk("rst_expire", {28'd0, expire_o}, 0);
    chk("rst_armed", {28'd0, armed_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 1);
    chk("rst_err", {31'd0, err_o}, 0);
    chk("rst_strobes", {30'd0, tmr_wren_o, tmr_rden_o}, 0);
    chk("rst_addr", tmr_addr_o, 0);
    chk("rst_data", tmr_data_o, 0);

    exp_wr(CtrlA, 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    begin : init_ack
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (tmr_ack_i) disable init_ack;
      end
      timeout("init_ack_wait");
    end
    chk("init_ready_during_ack", {31'd0, cmd_ready_o}, 0);
    @(negedge clk);
    chk("init_ready_after_ack", {31'd0, cmd_ready_o}, 1);
    chk("init_timer_stopped", {31'd0, tm_en}, 0);

    // Table: single arm from IDLE until expiry
    foreach (vecs[i]) begin
      exp_wr(CountA, 32'd0);
      exp_wr(ThresA, vecs[i].dur);
      exp_wr(CtrlA, 32'd1);
      exp_wr(CtrlA, 32'd0);
      exp_rd(CountA);
      send(1'b0, vecs[i].ch, vecs[i].dur, c);
      wait_exp(int'(vecs[i].dur) + 60, m, cyc);
      chk("vec_expire_mask", {28'd0, m}, {28'd0, vecs[i].mask});
      chk("vec_latency_in_range", {31'd0, (cyc >= int'(vecs[i].dur)) &&
                                          (cyc <= int'(vecs[i].dur) + 30)}, 1);
      chk("vec_disarmed", {28'd0, armed_o}, 0);
      @(negedge clk);
      chk("vec_pulse_one_cycle", {28'd0, expire_o}, 0);
      wait_idle();
      chk("vec_bus_drained", exp_q.size(), 0);
    end

    // Arm ch0 100, arm ch1 30 at count 40: elapsed is count+1 (tick on the accept edge).
    exp_wr(CountA, 32'd0);
    exp_wr(ThresA, 32'd100);
    exp_wr(CtrlA, 32'd1);
    send(1'b0, 2'd0, 32'd100, c);
    begin : wait40
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (tm_cnt == 32'd40) disable wait40;
      end
      timeout("count40_wait");
    end
    send(1'b0, 2'd1, 32'd30, c);
    r0 = 32'd100 - (c + 32'd1);
    // ch1 irq seen at count 30, frozen at 31
    r1 = r0 - 32'd31;
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, (r0 < 32'd30) ? r0 : 32'd30); exp_wr(CtrlA, 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, r1); exp_wr(CtrlA, 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    wait_exp(100, m, cyc);
    chk("mid_first_expire", {28'd0, m}, 32'b0010);
    chk("mid_ch0_still_armed", {28'd0, armed_o}, 32'b0001);
    wait_exp(100, m, cyc);
    chk("mid_second_expire", {28'd0, m}, 32'b0001);
    wait_idle();
    chk("mid_bus_drained", exp_q.size(), 0);

    // ch2 and ch3 timed to expire together
    exp_wr(CountA, 32'd0); exp_wr(ThresA, 32'd50); exp_wr(CtrlA, 32'd1);
    send(1'b0, 2'd2, 32'd50, c);
    wait_run();
    d3 = 32'd50 - (tm_cnt + 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, d3); exp_wr(CtrlA, 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    send(1'b0, 2'd3, d3, c);
    wait_exp(100, m, cyc);
    chk("pair_same_cycle", {28'd0, m}, 32'b1100);
    wait_idle();
    chk("pair_bus_drained", exp_q.size(), 0);

    // dur 0 arm, then re-arm in the same pass as its expiry
    exp_wr(CountA, 32'd0); exp_wr(ThresA, 32'd0); exp_wr(CtrlA, 32'd1);
    send(1'b0, 2'd0, 32'd0, c);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, 32'd10); exp_wr(CtrlA, 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    send(1'b0, 2'd0, 32'd10, c);
    wait_exp(40, m, cyc);
    chk("rearm_expire", {28'd0, m}, 32'b0001);
    chk("rearm_stays_armed", {28'd0, armed_o}, 32'b0001);
    wait_exp(60, m, cyc);
    chk("rearm_second_expire", {28'd0, m}, 32'b0001);
    wait_idle();
    chk("rearm_bus_drained", exp_q.size(), 0);

    // Cancel armed and unarmed channels
    pulses = n_exp_pulses;
    exp_wr(CountA, 32'd0); exp_wr(ThresA, 32'd60); exp_wr(CtrlA, 32'd1);
    send(1'b0, 2'd1, 32'd60, c);
    wait_run();
    send(1'b0, 2'd0, 32'd200, c);
    r1 = 32'd60 - (c + 32'd1);
    r0 = 32'd200;
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, r1); exp_wr(CtrlA, 32'd1);
    wait_run();
    repeat (5) @(negedge clk);
    send(1'b1, 2'd1, 32'd0, c);
    r0 = r0 - (c + 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, r0); exp_wr(CtrlA, 32'd1);
    wait_run();
    chk("cancel_armed_mask", {28'd0, armed_o}, 32'b0001);
    send(1'b1, 2'd3, 32'd0, c);
    r0 = r0 - (c + 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    exp_wr(CountA, 32'd0); exp_wr(ThresA, r0); exp_wr(CtrlA, 32'd1);
    wait_run();
    chk("cancel_unarmed_noop", {28'd0, armed_o}, 32'b0001);
    send(1'b1, 2'd0, 32'd0, c);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    wait_idle();
    chk("cancel_no_pulses", n_exp_pulses - pulses, 0);
    chk("cancel_bus_drained", exp_q.size(), 0);

    // Slave stops acknowledging during CLR
    stall = 1'b1;
    exp_wr(CountA, 32'd0);
    send(1'b0, 2'd0, 32'd5, c);
    repeat (40) @(negedge clk);
`ifdef CELLRV32_GPTMR_SCHED_BUSTO_EN
    chk("busto_err", {31'd0, err_o}, 1);
    chk("busto_disarmed", {28'd0, armed_o}, 0);
    chk("busto_idle", {31'd0, busy_o}, 0);
    stall = 1'b0;
    repeat (4) @(negedge clk);
    chk("busto_err_sticky", {31'd0, err_o}, 1);
`else
    chk("stall_no_err", {31'd0, err_o}, 0);
    chk("stall_busy", {31'd0, busy_o}, 1);
    chk("stall_armed", {28'd0, armed_o}, 32'b0001);
    exp_wr(ThresA, 32'd5); exp_wr(CtrlA, 32'd1);
    exp_wr(CtrlA, 32'd0); exp_rd(CountA);
    stall = 1'b0;
    wait_exp(60, m, cyc);
    chk("stall_resume_expire", {28'd0, m}, 32'b0001);
    wait_idle();
`endif
    chk("stall_bus_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
